// File: rtl/stage_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stage_mem: MIPS memory-access stage, RAM handshake and load extraction    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module stage_mem (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_register_write_enable,
  input  logic [4:0]  mem_register_write_address,
  input  logic [31:0] mem_register_write_data,
  input  logic [3:0]  mem_memory_operation,
  input  logic [31:0] mem_memory_address,
  input  logic [31:0] mem_memory_store_data,
  output logic        ram_enable,
  output logic        ram_write_enable,
  output logic [3:0]  ram_byte_select,
  output logic [31:0] ram_address,
  output logic [31:0] ram_write_data,
  input  logic [31:0] ram_read_data,
  input  logic        ram_ready,
  output logic        stall_request,
  output logic        address_error,
  output logic        mem_result_register_write_enable,
  output logic [4:0]  mem_result_register_write_address,
  output logic [31:0] mem_result_register_write_data
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam logic [3:0] c_op_lb  = 4'd1;
  localparam logic [3:0] c_op_lbu = 4'd2;
  localparam logic [3:0] c_op_lh  = 4'd3;
  localparam logic [3:0] c_op_lhu = 4'd4;
  localparam logic [3:0] c_op_lw  = 4'd5;
  localparam logic [3:0] c_op_sb  = 4'd6;
  localparam logic [3:0] c_op_sh  = 4'd7;
  localparam logic [3:0] c_op_sw  = 4'd8;

  state_t      r_state;
  logic [3:0]  r_op;
  logic [1:0]  r_lane;

  logic        w_is_mem;
  logic        w_misaligned;
  logic        w_valid;
  logic        w_we;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_r_is_load;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  always_comb begin
    w_is_mem     = (mem_memory_operation >= c_op_lb) && (mem_memory_operation <= c_op_sw);
    w_misaligned = 1'b0;
    w_we         = 1'b0;
    w_be         = 4'b0000;
    w_wdata      = 32'd0;
    case (mem_memory_operation)
      c_op_lb, c_op_lbu: w_be = 4'b0001 << mem_memory_address[1:0];
      c_op_lh, c_op_lhu: begin
        w_misaligned = mem_memory_address[0];
        w_be         = mem_memory_address[1] ? 4'b1100 : 4'b0011;
      end
      c_op_lw: begin
        w_misaligned = |mem_memory_address[1:0];
        w_be         = 4'b1111;
      end
      c_op_sb: begin
        w_we    = 1'b1;
        w_be    = 4'b0001 << mem_memory_address[1:0];
        w_wdata = {4{mem_memory_store_data[7:0]}};
      end
      c_op_sh: begin
        w_misaligned = mem_memory_address[0];
        w_we         = 1'b1;
        w_be         = mem_memory_address[1] ? 4'b1100 : 4'b0011;
        w_wdata      = {2{mem_memory_store_data[15:0]}};
      end
      c_op_sw: begin
        w_misaligned = |mem_memory_address[1:0];
        w_we         = 1'b1;
        w_be         = 4'b1111;
        w_wdata      = mem_memory_store_data;
      end
      default: ;
    endcase
    w_valid = w_is_mem && !w_misaligned;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state          <= IDLE;
      r_op             <= 4'd0;
      r_lane           <= 2'd0;
      ram_write_enable <= 1'b0;
      ram_byte_select  <= 4'd0;
      ram_address      <= 32'd0;
      ram_write_data   <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_op             <= mem_memory_operation;
            r_lane           <= mem_memory_address[1:0];
            ram_write_enable <= w_we;
            ram_byte_select  <= w_be;
            ram_address      <= {mem_memory_address[31:2], 2'b00};
            ram_write_data   <= w_wdata;
            r_state          <= ACCESS;
          end
        end
        ACCESS: begin
          if (ram_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ram_enable = (r_state == ACCESS);

  // Lane selection uses the copies captured at request time.
  always_comb begin
    w_r_is_load = (r_op >= c_op_lb) && (r_op <= c_op_lw);
    case (r_lane)
      2'd0:    w_byte = ram_read_data[7:0];
      2'd1:    w_byte = ram_read_data[15:8];
      2'd2:    w_byte = ram_read_data[23:16];
      default: w_byte = ram_read_data[31:24];
    endcase
    w_half = r_lane[1] ? ram_read_data[31:16] : ram_read_data[15:0];
    case (r_op)
      c_op_lb:  w_load_data = {{24{w_byte[7]}}, w_byte};
      c_op_lbu: w_load_data = {24'd0, w_byte};
      c_op_lh:  w_load_data = {{16{w_half[15]}}, w_half};
      c_op_lhu: w_load_data = {16'd0, w_half};
      default:  w_load_data = ram_read_data;
    endcase
  end

  always_comb begin
    stall_request                     = 1'b0;
    address_error                     = 1'b0;
    mem_result_register_write_enable  = 1'b0;
    mem_result_register_write_address = 5'd0;
    mem_result_register_write_data    = 32'd0;
    if (reset) begin
      mem_result_register_write_address = mem_register_write_address;
      if (r_state == ACCESS) begin
        stall_request                    = !ram_ready;
        mem_result_register_write_enable = ram_ready && w_r_is_load && mem_register_write_enable;
        mem_result_register_write_data   = w_load_data;
      end else begin
        stall_request                    = w_valid;
        address_error                    = w_is_mem && w_misaligned;
        mem_result_register_write_enable = !w_is_mem && mem_register_write_enable;
        mem_result_register_write_data   = mem_register_write_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/stage_mem.md
# stage_mem

Memory-access stage of the five-stage MIPS pipeline, between the EX/MEM latch and the MEM/WB latch. It decodes the memory operation carried out of the EX/MEM latch and runs a request/ready handshake with the data RAM. Load results are byte/halfword-extracted and sign- or zero-extended. The stage stalls the pipeline while an access is outstanding; non-memory instructions pass through in zero cycles.

## Interface
- No parameters.
- clock  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; state cleared on a rising edge with reset==0
- mem_register_write_enable  in  1  from EX/MEM latch
- mem_register_write_address  in  5  from EX/MEM latch
- mem_register_write_data  in  32  from EX/MEM latch; ALU result, passed through for non-loads
- mem_memory_operation  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9–15 treated as none
- mem_memory_address  in  32  effective byte address
- mem_memory_store_data  in  32  store source register value
- ram_enable  out  1  access request, held until ram_ready
- ram_write_enable  out  1  1 = store
- ram_byte_select  out  4  byte-lane strobes, bit i = bits 8i+7:8i
- ram_address  out  32  word address = {mem_memory_address[31:2], 2'b00}
- ram_write_data  out  32  lane-replicated store data
- ram_read_data  in  32  valid in the cycle ram_ready=1
- ram_ready  in  1  access completion, sampled only in ACCESS
- stall_request  out  1  holds PC/IF/ID/EX and the EX/MEM latch
- address_error  out  1  misaligned access detected
- mem_result_register_write_enable  out  1  to MEM/WB latch
- mem_result_register_write_address  out  5  to MEM/WB latch
- mem_result_register_write_data  out  32  to MEM/WB latch

## Operation
- FSM has two states: IDLE and ACCESS. Reset forces IDLE.
- Valid access: op in 1–8 and aligned.
- Misalignment rules:
  - LH, LHU and SH are misaligned when address[0]=1.
  - LW and SW are misaligned when address[1:0]!=0.
  - LB, LBU and SB are never misaligned.
- IDLE, with a valid access present:
  - stall_request=1.
  - ram_address, ram_write_enable, ram_byte_select, ram_write_data, the latched op and the latched address[1:0] are registered.
  - Next state is ACCESS.
- ACCESS:
  - ram_enable=1 and the registered RAM fields are held stable.
  - ram_ready=0: stall_request=1, the FSM stays in ACCESS.
  - ram_ready=1: stall_request=0, the result outputs are valid this cycle, next state is IDLE.
- IDLE with op none: stall_request=0, ram_enable=0, and all three result outputs equal the mem_register_write_* inputs combinationally.
- IDLE with a misaligned op:
  - address_error=1 combinationally.
  - No RAM access and no stall.
  - mem_result_register_write_enable=0.
- Load extraction (little-endian, lane = address[1:0]):
  - LB/LBU select byte [8·lane+7 : 8·lane]; LB sign-extends, LBU zero-extends.
  - LH/LHU select halfword [15:0] when address[1]=0 and [31:16] when address[1]=1; LH sign-extends, LHU zero-extends.
  - LW passes ram_read_data unchanged.
- Store formatting:
  - SB: byte replicated to all 4 lanes, byte_select = 1<<address[1:0].
  - SH: halfword replicated to both halves, byte_select = 0011 or 1100.
  - SW: byte_select=1111.
- Result outputs for memory ops:
  - Loads: write_enable=1 only in the ram_ready cycle (copied from the input), data = extracted value.
  - Stores: write_enable=0 throughout.
  - During a stall cycle write_enable=0, so the MEM/WB latch takes a bubble.
- The EX/MEM latch stays frozen during a stall, so the inputs are stable throughout ACCESS. The FSM still uses its registered copies for lane selection.

## Timing
- Reset values:
  - State IDLE.
  - ram_enable=0, ram_write_enable=0, ram_byte_select=0, ram_address=0, ram_write_data=0.
  - stall_request=0, address_error=0, all result outputs 0.
  - During reset the combinational paths are forced to 0.
- Minimum memory-op latency is 2 cycles:
  - Op arrives in cycle N (IDLE, stall).
  - ram_enable=1 from N+1; if ram_ready=1 in N+1, the result is valid and stall is released in N+1.
  - Each extra cycle ram_ready stays 0 adds one stall cycle.
- Back-to-back memory ops: the next op arrives in cycle N+2 in IDLE. There is no idle gap on the RAM bus beyond that one IDLE cycle.
- ram_ready while in IDLE is ignored.
- Reset during ACCESS: the FSM returns to IDLE and ram_enable=0 from the next cycle. The outstanding access is abandoned and no result is written.

## Test plan
- ALU pass-through: op=0, enable=1, addr=5, data=0x1234 → outputs 1/5/0x1234 in the same cycle; stall_request=0 and ram_enable=0 throughout.
- LB with sign extension: op=1, address=0x103, ram_read_data=0x80FF_0000, ram_ready=1 in cycle N+1 →
  - cycle N: stall=1;
  - cycle N+1: ram_address=0x100, byte_select=1000, result data=0xFFFF_FF80, enable=1, stall=0.
- LHU with 3 wait states: op=4, address=0x202, ram_read_data=0xBEEF_1234 →
  - stall=1 for cycles N..N+3;
  - ram_ready=1 in N+4 → data=0x0000_BEEF, stall=0 in N+4.
- SB: op=6, address=0x11, store_data=0x0000_00AB, ram_ready=1 in N+1 →
  - ram_write_enable=1, byte_select=0010, write_data=0xABAB_ABAB;
  - result enable=0.
- Misaligned LW: op=5, address=0x6 → address_error=1, stall=0, ram_enable=0, result enable=0.
- Reset mid-access: SW to 0x40, hold ram_ready=0, drive reset=0 in N+2 → ram_enable=0 and stall=0 from N+3; then op=0 passes through normally.
